altro_readout_rx: RTL
=====================

ALTRO_READOUT_RX -- requirements
Module: altro_readout_rx

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of capture FIFO depth (16 words of 40 bits).
REQ-002 SHALL have port rcu_clk  input  1  the only clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port trsf  input  1  transfer window from the fake ALTRO; high for the whole readout of one channel.
REQ-005 SHALL have port dstb  input  1  data strobe; each cycle high qualifies one word on bd_in.
REQ-006 SHALL have port bd_in  input  40  ALTRO bus word.
REQ-007 SHALL have port rd_en  input  1  FIFO read request from the downstream consumer.
REQ-008 SHALL have port dout  output  40  FIFO read data.
REQ-009 SHALL have port dout_valid  output  1  dout holds a freshly read word this cycle.
REQ-010 SHALL have port empty  output  1  FIFO empty.
REQ-011 SHALL have port full  output  1  FIFO full.
REQ-012 SHALL have port word_cnt  output  10  words strobed in the current or last frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of frame check.
REQ-014 SHALL have port len_err  output  1  trailer length mismatch for the last frame.
REQ-015 SHALL have port overflow  output  1  sticky; a strobed word was dropped because the FIFO was full.
REQ-016 SHALL have port timeout  output  1  sticky; watchdog abort (present only with RX_TIMEOUT_EN).

Function
REQ-017 SHALL implement FSM states IDLE, RECV, CHECK (plus ABORT with RX_TIMEOUT_EN).
REQ-018 SHALL move IDLE->RECV when trsf=1, clearing word_cnt, len_err, overflow and timeout in that same cycle.
REQ-019 SHALL, in RECV, on each cycle with dstb=1, write bd_in into the FIFO and increment word_cnt, which saturates at 1023.
REQ-020 SHALL also capture the bd_in sampled with dstb into a last-word register, independent of FIFO fullness.
REQ-021 SHALL drop a strobed word when full=1 and rd_en=0, set overflow, and still increment word_cnt.
REQ-022 SHALL allow a simultaneous write and read when full=1; both proceed, and full stays 1.
REQ-023 SHALL move RECV->CHECK on the first cycle with trsf=0; a dstb in that cycle is ignored.
REQ-024 SHALL, in CHECK (one cycle), set len_err = (word_cnt==0) or (last_word[25:16] != word_cnt-1), pulse frame_done, then return to IDLE.
REQ-025 SHALL ignore dstb in IDLE and CHECK.
REQ-026 SHALL give dout_valid=1 and the FIFO head on dout one cycle after rd_en=1 while empty=0; rd_en while empty is ignored and dout holds its value.
REQ-027 SHALL update empty and full in the cycle after the write or read that changes them; pointers SHALL be FIFO_AW+1 bits with wrap-around.
REQ-028 SHALL NOT reset the FIFO contents or pointers at frame start; frames concatenate in the FIFO.

Reset
REQ-029 SHALL, on reset, force the FSM to IDLE, both pointers to 0, and set outputs to: dout=0, dout_valid=0, empty=1, full=0, word_cnt=0, frame_done=0, len_err=0, overflow=0, timeout=0.
REQ-030 SHALL, on reset mid-frame, abandon the frame with no frame_done; a trsf still high after release SHALL start a new frame.

Configuration
REQ-031 SHALL, with macro RX_TIMEOUT_EN defined, count cycles in RECV since the last dstb; at 256 cycles it SHALL set timeout and enter ABORT.
REQ-032 SHALL stay in ABORT until trsf=0, then return to IDLE without a frame_done pulse.
REQ-033 SHALL, without RX_TIMEOUT_EN, contain no watchdog counter and no ABORT state, and drive timeout constant 0.

Verification
REQ-034 Frame test: trsf high; 4 dstb with words W0..W2 and trailer 40'h00_0003_0000 (bits[25:16]=3); trsf low -> word_cnt=4, frame_done pulse, len_err=0, 4 words readable in order.
REQ-035 Bad trailer: same frame with trailer bits[25:16]=5 -> len_err=1 after frame_done.
REQ-036 Overflow: 20 dstb with no rd_en -> 16 words stored, overflow=1, full=1, word_cnt=20; then 16 rd_en -> empty=1.
REQ-037 Full with read: full FIFO, dstb and rd_en in the same cycle -> new word stored, oldest word out, overflow stays 0.
REQ-038 Reset mid-frame: reset after 2 dstb -> empty=1, word_cnt=0, no frame_done.
REQ-039 Timeout (with RX_TIMEOUT_EN): trsf high, 1 dstb, then 256 idle cycles -> timeout=1; on trsf low, return to IDLE with no frame_done.

Source files
------------

// File: rtl/altro_readout_rx.sv
// altro_readout_rx: captures ALTRO bus words strobed during a transfer window into a
// FIFO and checks the trailer length of each frame.
// Ports: rcu_clk/reset (async, active-high); trsf/dstb/bd_in bus input; rd_en/dout/
// dout_valid/empty/full FIFO read side; word_cnt/frame_done/len_err/overflow/timeout status.
// Optional macro RX_TIMEOUT_EN adds a 256-cycle dstb watchdog and an ABORT state.
module altro_readout_rx #(
  parameter int FIFO_AW = 4
) (
  input  logic        rcu_clk,
  input  logic        reset,
  input  logic        trsf,
  input  logic        dstb,
  input  logic [39:0] bd_in,
  input  logic        rd_en,
  output logic [39:0] dout,
  output logic        dout_valid,
  output logic        empty,
  output logic        full,
  output logic [9:0]  word_cnt,
  output logic        frame_done,
  output logic        len_err,
  output logic        overflow,
  output logic        timeout
);
  typedef enum logic [1:0] {
    IDLE, RECV, CHECK
`ifdef RX_TIMEOUT_EN
    , ABORT
`endif
  } state_t;
  localparam int DEPTH = 1 << FIFO_AW;
  logic [39:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [39:0] dout_q, dout_d;
  logic dout_valid_q, dout_valid_d, empty_q, empty_d, full_q, full_d;
  logic [9:0] word_cnt_q, word_cnt_d, last_len_q, last_len_d;
  logic frame_done_q, frame_done_d, len_err_q, len_err_d, overflow_q, overflow_d;
  logic strb, wr, rd;
`ifdef RX_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    strb = (state_q == RECV) && trsf && dstb;
    // a full FIFO still accepts a word when a read frees a slot in the same cycle
    wr = strb && (!full_q || rd_en);
    rd = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(wr);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(rd);
    empty_d = wr_ptr_d == rd_ptr_d;
    full_d = (wr_ptr_d ^ rd_ptr_d) == {1'b1, {FIFO_AW{1'b0}}};
    dout_d = rd ? mem[rd_ptr_q[FIFO_AW-1:0]] : dout_q;
    dout_valid_d = rd;
    // only the trailer length field of the last strobed word is ever checked
    last_len_d = strb ? bd_in[25:16] : last_len_q;
    word_cnt_d = strb ? word_cnt_q + 10'(word_cnt_q != 10'h3ff) : word_cnt_q;
    overflow_d = overflow_q || (strb && !wr);
    len_err_d = len_err_q;
    frame_done_d = 1'b0;
    state_d = state_q;
`ifdef RX_TIMEOUT_EN
    wdog_d = wdog_q;
    timeout_d = timeout_q;
`endif
    if (state_q == IDLE && trsf) begin
      state_d = RECV;
      word_cnt_d = '0;
      len_err_d = 1'b0;
      overflow_d = 1'b0;
`ifdef RX_TIMEOUT_EN
      wdog_d = '0;
      timeout_d = 1'b0;
`endif
    end else if (state_q == RECV && !trsf) begin
      state_d = CHECK;
    end else if (state_q == CHECK) begin
      state_d = IDLE;
      frame_done_d = 1'b1;
      len_err_d = (word_cnt_q == '0) || (last_len_q != word_cnt_q - 10'd1);
    end
`ifdef RX_TIMEOUT_EN
    else if (state_q == RECV) begin
      // wdog_q==255 on a strobeless cycle marks the 256th idle cycle
      wdog_d = dstb ? 8'd0 : wdog_q + 8'd1;
      if (!dstb && wdog_q == 8'hff) begin
        timeout_d = 1'b1;
        state_d = ABORT;
      end
    end else if (state_q == ABORT && !trsf) begin
      state_d = IDLE;
    end
`endif
  end
  always_ff @(posedge rcu_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      word_cnt_q <= '0;
      last_len_q <= '0;
      frame_done_q <= 1'b0;
      len_err_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
      wdog_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
      empty_q <= empty_d;
      full_q <= full_d;
      word_cnt_q <= word_cnt_d;
      last_len_q <= last_len_d;
      frame_done_q <= frame_done_d;
      len_err_q <= len_err_d;
      overflow_q <= overflow_d;
`ifdef RX_TIMEOUT_EN
      wdog_q <= wdog_d;
      timeout_q <= timeout_d;
`endif
    end
  end
  always_ff @(posedge rcu_clk) begin
    if (wr) mem[wr_ptr_q[FIFO_AW-1:0]] <= bd_in;
  end
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign empty = empty_q;
  assign full = full_q;
  assign word_cnt = word_cnt_q;
  assign frame_done = frame_done_q;
  assign len_err = len_err_q;
  assign overflow = overflow_q;
endmodule
